uart_tx_frame_shifter: RTL

Parametrised successor to the fixed 11-bit UART transmit shift register.
- Builds a complete asynchronous serial frame from a parallel word and shifts it out LSB-first on sdo: start bit, DATA_W data bits, optional parity, then 1 or 2 stop bits.
- Generates its own bit timing from an internal baud divider and uses a valid/ready load handshake.
- Sits between the host-side TX data source (FIFO or register) and the TX pin.

---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_baud_tick.sv | 47 ++++
 rtl/uart_tx_frame_shifter.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit frame shifter:
//   - parity_mode encodings (PAR_NONE / PAR_EVEN / PAR_ODD; 2'b11 behaves as none)
//   - shifter state enum
//   - frame-length and parity-enable helper functions
// ----------------------------------------------------------------------------
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    // Reserved encoding 2'b11 falls through to "no parity bit".
    function automatic logic parity_enabled(input logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

    // Frame length in bits: start + data + optional parity + 1 or 2 stop bits.
    function automatic logic [3:0] frame_len(input int data_w, input logic par_en,
                                             input logic stop2);
        return 4'(1 + data_w + (par_en ? 1 : 0) + (stop2 ? 2 : 1));
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// ----------------------------------------------------------------------------
// uart_baud_tick
// Modulo-BAUD_DIV counter that pulses tick_o on the last clk cycle of each
// serial bit period.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   clr_i      : synchronous clear to 0 (restarts the bit period)
//   en_i       : count enable
//   tick_o     : high during the final cycle of a bit period
// ----------------------------------------------------------------------------
module uart_baud_tick #(
    parameter int BAUD_DIV = 868
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic tick_o
);

    localparam int                CNT_W = $clog2(BAUD_DIV);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(BAUD_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i)
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end

    // tick_o deliberately ignores clr_i: the top uses tick_o to decide when to
    // clear, so gating it here would form a combinational loop.
    assign tick_o = en_i && (cnt_q == LAST);

    // NOTE: state is updated with <= only; blocking assignments here would let
    // readers in other always_ff blocks see the new value in the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/uart_tx_frame_shifter.sv
// ----------------------------------------------------------------------------
// uart_tx_frame_shifter
// Builds an asynchronous serial frame (start, DATA_W data bits LSB first,
// optional parity, 1 or 2 stop bits) and shifts it out on sdo, one bit per
// BAUD_DIV clk cycles, with a valid/ready load handshake.
// Ports:
//   clk, reset       : clock, asynchronous active-high reset
//   tx_data          : word to send      tx_valid / tx_ready : load handshake
//   parity_mode      : 00 none, 01 even, 10 odd, 11 none
//   stop2            : 1 selects two stop bits
//   sdo              : serial out, idles high
//   busy             : frame in progress  done : 1-cycle pulse at frame end
// Build option UART_TX_HOLD_EN: one-entry holding register so that a word can
// be accepted during a frame and sent with zero idle cycles after it.
// ----------------------------------------------------------------------------
module uart_tx_frame_shifter
    import uart_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int BAUD_DIV = 868
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [1:0]        parity_mode,
    input  logic              stop2,
    output logic              sdo,
    output logic              busy,
    output logic              done
);

    localparam int SR_W = DATA_W + 4;

    state_e            state_q, state_d;
    logic [SR_W-1:0]   sr_q, sr_d;
    logic [3:0]        bits_q, bits_d;
    logic              done_q, done_d;

    logic              tick;
    logic              baud_clr;
    logic              accept;
    logic              frame_end;
    logic [SR_W-1:0]   new_sr;
    logic [3:0]        new_len;

`ifdef UART_TX_HOLD_EN
    logic              hold_full_q, hold_full_d;
    logic [SR_W-1:0]   hold_sr_q, hold_sr_d;
    logic [3:0]        hold_len_q, hold_len_d;

    assign tx_ready = !hold_full_q;
`else
    assign tx_ready = (state_q == IDLE);
`endif

    assign accept    = tx_valid && tx_ready;
    assign frame_end = (state_q == SHIFT) && tick && (bits_q == 4'd1);

    uart_baud_tick #(
        .BAUD_DIV (BAUD_DIV)
    ) u_baud (
        .clk    (clk),
        .reset  (reset),
        .clr_i  (baud_clr),
        .en_i   (state_q == SHIFT),
        .tick_o (tick)
    );

    // Frame image of the word on tx_data, sampled at the accepting edge.
    // Unused upper positions stay 1 so they read as stop/idle level.
    always_comb begin
        new_sr         = '1;
        new_sr[0]      = 1'b0;
        new_sr[DATA_W:1] = tx_data;
        if (parity_enabled(parity_mode))
            new_sr[DATA_W+1] = (parity_mode == PAR_ODD) ? ~^tx_data : ^tx_data;
        new_len = frame_len(DATA_W, parity_enabled(parity_mode), stop2);
    end

    // NOTE: every signal this block drives gets a default first, so no path
    // can leave one unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        sr_d     = sr_q;
        bits_d   = bits_q;
        done_d   = 1'b0;
        baud_clr = 1'b0;
`ifdef UART_TX_HOLD_EN
        hold_full_d = hold_full_q;
        hold_sr_d   = hold_sr_q;
        hold_len_d  = hold_len_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    sr_d     = new_sr;
                    bits_d   = new_len;
                    baud_clr = 1'b1;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                if (tick) begin
                    sr_d   = {1'b1, sr_q[SR_W-1:1]};
                    bits_d = bits_q - 4'd1;
                end
                if (frame_end) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
`ifdef UART_TX_HOLD_EN
                // A pending word (held, or arriving on the very last cycle)
                // replaces the drained frame on the same edge: no idle gap.
                if (frame_end && hold_full_q) begin
                    sr_d        = hold_sr_q;
                    bits_d      = hold_len_q;
                    baud_clr    = 1'b1;
                    hold_full_d = 1'b0;
                    state_d     = SHIFT;
                end else if (frame_end && accept) begin
                    sr_d     = new_sr;
                    bits_d   = new_len;
                    baud_clr = 1'b1;
                    state_d  = SHIFT;
                end else if (accept) begin
                    hold_sr_d   = new_sr;
                    hold_len_d  = new_len;
                    hold_full_d = 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            sr_q    <= '1;
            bits_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            bits_q  <= bits_d;
            done_q  <= done_d;
        end
    end

`ifdef UART_TX_HOLD_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_full_q <= 1'b0;
            hold_sr_q   <= '1;
            hold_len_q  <= '0;
        end else begin
            hold_full_q <= hold_full_d;
            hold_sr_q   <= hold_sr_d;
            hold_len_q  <= hold_len_d;
        end
    end
`endif

    // sr_q resets to all ones, so sdo goes high the moment reset asserts.
    assign sdo  = sr_q[0];
    assign busy = (state_q == SHIFT);
    assign done = done_q;

endmodule
